motor_drive: RTL and testbench
==============================

MOTOR_DRIVE -- requirements
Module: motor_drive

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 100_000_000, giving the dwell-timer length in clkin cycles.
REQ-002 SHALL have parameter RAMP_TICK, default 1_000_000, giving clkin cycles per duty ramp step.
REQ-003 SHALL have parameter DUTY_STEP, default 16, giving the duty increment/decrement per ramp step.
REQ-004 SHALL have parameter TURN_DUTY, default 160, giving the fixed duty for LEFT/RIGHT/BACKWARD.
REQ-005 SHALL have the port clkin (input, 1 bit): the single system clock.
REQ-006 SHALL have the port reset_n (input, 1 bit): reset, asynchronous, active-low.
REQ-007 SHALL have the port direction (input, 7 bits): one-hot state from the motor FSM: bit0 FORWARD, bit1 IDLE, bit2 BACKWARD, bit3 LEFT, bit4 RIGHT, bit5 ACC, bit6 DEC.
REQ-008 SHALL have the port start_timer (input, 1 bit): a one-cycle pulse that (re)starts the dwell timer.
REQ-009 SHALL have the port start_milli_timer (input, 1 bit): a one-cycle pulse that restarts the ramp prescaler phase.
REQ-010 SHALL have the port timer_expire (output, 1 bit): a one-cycle pulse when the dwell completes.
REQ-011 SHALL have the port accelerated (output, 1 bit): a level, high when direction==ACC and duty==255.
REQ-012 SHALL have the port decelerated (output, 1 bit): a level, high when direction==DEC and duty==0.
REQ-013 SHALL have the port duty (output, 8 bits): the current PWM duty register.
REQ-014 SHALL have the ports pwm_a and pwm_b (outputs, 1 bit each): the H-bridge enable PWM for the left and right motors.
REQ-015 SHALL have the ports ain1, ain2, bin1 and bin2 (outputs, 1 bit each): the H-bridge direction pins for the left (a) and right (b) motors.

Function
REQ-016 The dwell timer SHALL load DWELL_CYCLES-1 on start_timer, decrement every cycle while running, and pulse timer_expire for exactly one cycle on the cycle after reaching 0.
REQ-017 A start_timer pulse while the dwell timer is running SHALL reload the count with no expire pulse; when idle, timer_expire SHALL stay 0.
REQ-018 The ramp prescaler SHALL count 0..RAMP_TICK-1 with wrap, issue one tick per wrap, and clear to 0 on start_milli_timer, with the first tick RAMP_TICK cycles after the pulse.
REQ-019 The duty register SHALL update per current direction:
  - ACC: on each tick, duty = min(duty+DUTY_STEP, 255), saturating with no 8-bit wrap.
  - DEC: on each tick, duty = max(duty-DUTY_STEP, 0), saturating.
  - FORWARD: 255 on the next cycle.
  - IDLE: 0 on the next cycle.
  - LEFT/RIGHT/BACKWARD: TURN_DUTY on the next cycle.
  - Non-one-hot direction: treated as IDLE.
REQ-020 accelerated and decelerated SHALL be combinational from registered duty and direction only, with no path from start_timer or start_milli_timer, so there is no loop through the FSM's Mealy logic.
REQ-021 The PWM SHALL use a free-running 8-bit counter, with pwm_a = pwm_b = (pwm_cnt < duty), giving duty/256 high time and a 256-cycle period.
REQ-022 The H-bridge direction pins {ain1,ain2,bin1,bin2} SHALL be 1010 for FORWARD/ACC/DEC, 0101 for BACKWARD, 0110 for LEFT, 1001 for RIGHT, and 0000 (coast) for IDLE or a non-one-hot direction.
REQ-023 The direction pins and PWM outputs SHALL be registered, giving a one-cycle latency from direction.
REQ-024 When start_timer and start_milli_timer arrive in the same cycle, both SHALL be honoured independently.
REQ-025 A direction change mid-ramp SHALL leave the prescaler running and apply the new direction's duty rule from the next cycle.

Reset
REQ-026 Asserting reset_n low SHALL immediately clear, without waiting for a clock edge: duty, both counters, pwm_cnt, timer_expire, pwm_a/pwm_b, and all four direction pins; the dwell timer SHALL be idle.
REQ-027 Reset asserted mid-dwell or mid-ramp SHALL abort the operation, with no expire pulse after release.
REQ-028 Deassertion of reset_n SHALL be synchronized externally; the first active edge SHALL behave as the idle state.

Structure
REQ-029 The direction one-hot constants SHALL live in the shared package motors_pkg, used by both motor_drive and the motor FSM.
REQ-030 The PWM counter/compare SHALL be a sub-module pwm_gen (clkin, reset_n, duty -> pwm), instantiated once, driving both pwm_a and pwm_b.

Verification (DWELL_CYCLES=10, RAMP_TICK=4, DUTY_STEP=64, TURN_DUTY=160)
REQ-031 Dwell: start_timer at cycle 0 -> timer_expire high in exactly cycle 10, low otherwise; a second start_timer at cycle 5 moves expire to cycle 15.
REQ-032 Acceleration: direction=ACC from duty 0 with start_milli_timer -> duty 64, 128, 192, 255 at ticks 1-4 (saturated, not 0), and accelerated high from tick 4.
REQ-033 Deceleration: direction=DEC from duty 255 -> duty 191, 127, 63, 0, and decelerated high after tick 4; duty holds at 0 on tick 5.
REQ-034 Steering: direction=RIGHT -> next cycle pins 1001, duty 160, pwm high 160 of every 256 cycles; an illegal direction 7'b0000011 -> pins 0000, duty 0.
REQ-035 Reset: reset_n low during ACC at duty 128 mid-dwell -> duty, pins and pwm 0 immediately, and no timer_expire after release.

Source files
------------

// File: rtl/motors_pkg.sv
// Shared motor-control definitions: one-hot direction codes and H-bridge pin patterns.
package motors_pkg;

  typedef enum logic [6:0] {
    DIR_FORWARD  = 7'b0000001,
    DIR_IDLE     = 7'b0000010,
    DIR_BACKWARD = 7'b0000100,
    DIR_LEFT     = 7'b0001000,
    DIR_RIGHT    = 7'b0010000,
    DIR_ACC      = 7'b0100000,
    DIR_DEC      = 7'b1000000
  } dir_e;

  // {ain1, ain2, bin1, bin2}
  localparam logic [3:0] PINS_FWD   = 4'b1010;
  localparam logic [3:0] PINS_BACK  = 4'b0101;
  localparam logic [3:0] PINS_LEFT  = 4'b0110;
  localparam logic [3:0] PINS_RIGHT = 4'b1001;
  localparam logic [3:0] PINS_COAST = 4'b0000;

  // Maps a direction to bridge pins; anything not one-hot coasts.
  function automatic logic [3:0] bridge_pins(input logic [6:0] dir);
    logic [3:0] pins;
    pins = PINS_COAST;
    case (dir)
      DIR_FORWARD, DIR_ACC, DIR_DEC: pins = PINS_FWD;
      DIR_BACKWARD:                  pins = PINS_BACK;
      DIR_LEFT:                      pins = PINS_LEFT;
      DIR_RIGHT:                     pins = PINS_RIGHT;
      default:                       pins = PINS_COAST;
    endcase
    return pins;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running 8-bit PWM: output high while the counter is below duty.
module pwm_gen (
  input  logic       clkin,
  input  logic       reset_n,
  input  logic [7:0] duty,
  output logic       pwm
);

  logic [7:0] pwm_cnt;

  // Counter wraps every 256 cycles; compare result is registered.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
      pwm     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      pwm     <= (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/motor_drive.sv
// Motor drive datapath: dwell timer, ramp prescaler, duty register, H-bridge pins and PWM.
module motor_drive
  import motors_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 100_000_000,
  parameter int unsigned RAMP_TICK    = 1_000_000,
  parameter int unsigned DUTY_STEP    = 16,
  parameter int unsigned TURN_DUTY    = 160
) (
  input  logic       clkin,
  input  logic       reset_n,
  input  logic [6:0] direction,
  input  logic       start_timer,
  input  logic       start_milli_timer,
  output logic       timer_expire,
  output logic       accelerated,
  output logic       decelerated,
  output logic [7:0] duty,
  output logic       pwm_a,
  output logic       pwm_b,
  output logic       ain1,
  output logic       ain2,
  output logic       bin1,
  output logic       bin2
);

  localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned RW = (RAMP_TICK > 1) ? $clog2(RAMP_TICK) : 1;

  logic [DW-1:0] dwell_cnt;
  logic          dwell_run;
  logic [RW-1:0] ramp_cnt;
  logic          tick;
  logic [7:0]    duty_next;
  logic [9:0]    duty_sum;
  logic          pwm;

  // Dwell timer: a new start always reloads; expire pulses one cycle after hitting zero.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      dwell_cnt    <= '0;
      dwell_run    <= 1'b0;
      timer_expire <= 1'b0;
    end else begin
      timer_expire <= 1'b0;
      if (start_timer) begin
        dwell_cnt <= DW'(DWELL_CYCLES - 1);
        dwell_run <= 1'b1;
      end else if (dwell_run) begin
        if (dwell_cnt == '0) begin
          timer_expire <= 1'b1;
          dwell_run    <= 1'b0;
        end else begin
          dwell_cnt <= dwell_cnt - DW'(1);
        end
      end
    end
  end

  // A restart cancels a tick that would have coincided with it, so the phase is set purely by the pulse.
  assign tick = !start_milli_timer && (ramp_cnt == RW'(RAMP_TICK - 1));

  // Ramp prescaler: wraps at RAMP_TICK, cleared by start_milli_timer.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      ramp_cnt <= '0;
    end else if (start_milli_timer) begin
      ramp_cnt <= '0;
    end else if (ramp_cnt == RW'(RAMP_TICK - 1)) begin
      ramp_cnt <= '0;
    end else begin
      ramp_cnt <= ramp_cnt + RW'(1);
    end
  end

  // Duty update rule for the current direction, saturating ramps.
  always_comb begin
    duty_next = duty;
    duty_sum  = {2'b00, duty} + 10'(DUTY_STEP);
    case (direction)
      DIR_ACC: if (tick) duty_next = (duty_sum > 10'd255) ? 8'hFF : duty_sum[7:0];
      DIR_DEC: if (tick) duty_next = ({2'b00, duty} < 10'(DUTY_STEP)) ? '0 : duty - 8'(DUTY_STEP);
      DIR_FORWARD:                   duty_next = 8'hFF;
      DIR_LEFT, DIR_RIGHT, DIR_BACKWARD: duty_next = 8'(TURN_DUTY);
      default:                       duty_next = '0;
    endcase
  end

  // Duty and bridge pins are registered from the current direction.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      duty                     <= '0;
      {ain1, ain2, bin1, bin2} <= '0;
    end else begin
      duty                     <= duty_next;
      {ain1, ain2, bin1, bin2} <= bridge_pins(direction);
    end
  end

  assign accelerated = (direction == DIR_ACC) && (duty == 8'hFF);
  assign decelerated = (direction == DIR_DEC) && (duty == 8'h00);

  pwm_gen u_pwm (
    .clkin   (clkin),
    .reset_n (reset_n),
    .duty    (duty),
    .pwm     (pwm)
  );

  assign pwm_a = pwm;
  assign pwm_b = pwm;

endmodule

// File: tb/tb_motor_drive.sv
// Self-checking bench for motor_drive: directed scenarios plus randomized traffic against an edge-count model.
module tb_motor_drive;

  localparam int DW = 10;
  localparam int RT = 4;
  localparam int DS = 64;
  localparam int TD = 160;

  logic       clkin = 1'b0;
  logic       reset_n = 1'b1;
  logic [6:0] direction = 7'b0000010;
  logic       start_timer = 1'b0;
  logic       start_milli_timer = 1'b0;
  logic       timer_expire, accelerated, decelerated;
  logic [7:0] duty;
  logic       pwm_a, pwm_b, ain1, ain2, bin1, bin2;

  motor_drive #(
    .DWELL_CYCLES (DW),
    .RAMP_TICK    (RT),
    .DUTY_STEP    (DS),
    .TURN_DUTY    (TD)
  ) dut (
    .clkin             (clkin),
    .reset_n           (reset_n),
    .direction         (direction),
    .start_timer       (start_timer),
    .start_milli_timer (start_milli_timer),
    .timer_expire      (timer_expire),
    .accelerated       (accelerated),
    .decelerated       (decelerated),
    .duty              (duty),
    .pwm_a             (pwm_a),
    .pwm_b             (pwm_b),
    .ain1              (ain1),
    .ain2              (ain2),
    .bin1              (bin1),
    .bin2              (bin2)
  );

  always #5 clkin = ~clkin;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: edges counted since reset, edge of last prescaler clear, dwell deadline edge.
  int         m_edge = 0;
  int         m_clr = 0;
  int         m_deadline = -1;
  logic       m_exp = 1'b0;
  int         m_duty = 0;
  logic [3:0] m_pins = 4'b0000;
  logic       m_pwm = 1'b0;

  function automatic int duty_rule(input logic [6:0] d, input int cur, input bit tk);
    case (d)
      7'b0100000: return tk ? ((cur + DS > 255) ? 255 : cur + DS) : cur;
      7'b1000000: return tk ? ((cur - DS < 0) ? 0 : cur - DS) : cur;
      7'b0000001: return 255;
      7'b0000100, 7'b0001000, 7'b0010000: return TD;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] pins_rule(input logic [6:0] d);
    case (d)
      7'b0000001, 7'b0100000, 7'b1000000: return 4'b1010;
      7'b0000100: return 4'b0101;
      7'b0001000: return 4'b0110;
      7'b0010000: return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  // Reference model advanced on each active edge.
  always @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      m_edge     <= 0;
      m_clr      <= 0;
      m_deadline <= -1;
      m_exp      <= 1'b0;
      m_duty     <= 0;
      m_pins     <= 4'b0000;
      m_pwm      <= 1'b0;
    end else begin
      m_exp <= !start_timer && (m_edge + 1 == m_deadline);
      if (start_timer) m_deadline <= m_edge + 1 + DW;
      if (start_milli_timer) m_clr <= m_edge + 1;
      m_duty <= duty_rule(direction, m_duty,
                          !start_milli_timer && (((m_edge + 1 - m_clr) % RT) == 0));
      m_pwm  <= (m_edge % 256) < m_duty;
      m_pins <= pins_rule(direction);
      m_edge <= m_edge + 1;
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clkin) begin
    chk("duty", int'(duty), m_duty);
    chk("pins", int'({ain1, ain2, bin1, bin2}), int'(m_pins));
    chk("pwm_a", int'(pwm_a), int'(m_pwm));
    chk("pwm_b", int'(pwm_b), int'(m_pwm));
    chk("timer_expire", int'(timer_expire), int'(m_exp));
    chk("accelerated", int'(accelerated), int'(direction == 7'b0100000 && m_duty == 255));
    chk("decelerated", int'(decelerated), int'(direction == 7'b1000000 && m_duty == 0));
  end

  task automatic step();
    @(posedge clkin);
    #2;
  endtask

  int acc_exp[5] = '{64, 128, 192, 255, 255};
  int dec_exp[5] = '{191, 127, 63, 0, 0};

  initial begin : stim
    int hi;
    logic [6:0] d;

    #1 reset_n = 1'b0;
    #1;
    chk("reset_duty", int'(duty), 0);
    chk("reset_pins", int'({ain1, ain2, bin1, bin2}), 0);
    chk("reset_pwm", int'(pwm_a), 0);
    chk("reset_expire", int'(timer_expire), 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    step();

    // Single dwell: expire exactly DW edges after the start edge.
    start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("dwell_single", int'(timer_expire), int'(k == 10));
    end

    // Restart at edge 5 pushes expire to edge 15.
    start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      if (k == 5) start_timer = 1'b1;
      step();
      start_timer = 1'b0;
      chk("dwell_restart", int'(timer_expire), int'(k == 15));
    end

    // Acceleration from zero with saturation.
    direction = 7'b0000010;
    step();
    direction = 7'b0100000;
    start_milli_timer = 1'b1;
    step();
    start_milli_timer = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k % 4 == 0) chk("acc_duty", int'(duty), acc_exp[k/4-1]);
      chk("acc_flag", int'(accelerated), int'(k >= 16));
    end

    // Deceleration from full to zero, holding at zero.
    direction = 7'b0000001;
    step();
    chk("fwd_duty", int'(duty), 255);
    direction = 7'b1000000;
    start_milli_timer = 1'b1;
    step();
    start_milli_timer = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k % 4 == 0) chk("dec_duty", int'(duty), dec_exp[k/4-1]);
      chk("dec_flag", int'(decelerated), int'(k >= 16));
    end

    // Steering right, then an illegal code.
    direction = 7'b0010000;
    step();
    chk("right_pins", int'({ain1, ain2, bin1, bin2}), 4'b1001);
    chk("right_duty", int'(duty), 160);
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      hi += int'(pwm_a);
    end
    chk("right_pwm_high", hi, 160);
    direction = 7'b0000011;
    step();
    chk("illegal_pins", int'({ain1, ain2, bin1, bin2}), 0);
    chk("illegal_duty", int'(duty), 0);

    // Reset mid-ramp and mid-dwell.
    direction = 7'b0000010;
    step();
    direction = 7'b0100000;
    start_milli_timer = 1'b1;
    start_timer = 1'b1;
    step();
    start_milli_timer = 1'b0;
    start_timer = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    chk("pre_reset_duty", int'(duty), 128);
    #1 reset_n = 1'b0;
    #1;
    chk("async_duty", int'(duty), 0);
    chk("async_pins", int'({ain1, ain2, bin1, bin2}), 0);
    chk("async_pwm", int'(pwm_a | pwm_b), 0);
    step();
    step();
    reset_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("no_expire_after_reset", int'(timer_expire), 0);
    end

    // Randomized traffic checked by the model every cycle.
    d = 7'b0000010;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 9) == 0) d = 7'($urandom_range(0, 127));
        else d = 7'(1 << $urandom_range(0, 6));
      end
      direction = d;
      start_timer = ($urandom_range(0, 29) == 0);
      start_milli_timer = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end
      step();
    end
    start_timer = 1'b0;
    start_milli_timer = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
